// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates data-memory waits,
// taken branches and load-use hazards, and keeps stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_acc, load_use, force_rel, freeze;
  logic              sel_branch, sel_load_use;

  always_comb begin
    mem_acc      = mem_MemRead | mem_MemWrite;
    load_use     = ex_MemRead && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    force_rel    = (state == MEM_WAIT) && (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    freeze       = mem_acc && !dmem_ready && !force_rel;
    sel_branch   = !freeze && ex_branch_taken;
    sel_load_use = !freeze && !ex_branch_taken && load_use;
  end

  // Output decode: freeze beats branch beats load-use; reset forces bubbles everywhere.
  always_comb begin
    dmem_req     = mem_acc;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      dmem_req     = 1'b0;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (sel_branch) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (sel_load_use) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  // Any reason freeze is low (ready, forced release, access withdrawn) ends the wait.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (freeze) state_next = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state <= state_next;
      if (freeze) begin
        if (state == RUN) wait_cnt <= '0;
        else              wait_cnt <= wait_cnt + 1'b1;
      end
      if (force_rel) err_timeout <= 1'b1;
      if ((freeze || sel_load_use) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (sel_branch && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl, using a small counter width
// and short timeout so saturation and forced release are both reachable.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       mr;
    logic       mw;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic             chk_regs;
    logic             dmem_req;
    logic             pc_write;
    logic             ifid_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic             err;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs2, ex_MemRead, ex_branch_taken, mem_MemRead, mem_MemWrite, dmem_ready;
  logic dmem_req, pc_write, ifid_write, exmem_write, ifid_flush, idex_flush, memwb_bubble;
  logic err_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  // Reference model state: counters, sticky error and the length of the current memory wait.
  int m_stall = 0;
  int m_flush = 0;
  bit m_err = 0;
  int m_frozen = 0;
  bit m_first = 1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_write(pc_write), .ifid_write(ifid_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .err_timeout(err_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic stim_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic uses2,
                               logic [4:0] rd, logic ld, logic br, logic mr, logic mw, logic rdy);
    stim_t s;
    s.rst = rst; s.rs1 = rs1; s.rs2 = rs2; s.uses2 = uses2; s.rd = rd;
    s.ld = ld; s.br = br; s.mr = mr; s.mw = mw; s.rdy = rdy;
    return s;
  endfunction

  // Drive one cycle of inputs just after the edge, predict the response and advance the model.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit acc, lu, forced, frz;
    @(posedge clk);
    #1;
    reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs2 = s.uses2; ex_rd = s.rd;
    ex_MemRead = s.ld; ex_branch_taken = s.br; mem_MemRead = s.mr; mem_MemWrite = s.mw;
    dmem_ready = s.rdy;

    acc    = s.mr || s.mw;
    lu     = s.ld && s.rd != 0 && (s.rd == s.rs1 || (s.uses2 && s.rd == s.rs2));
    forced = (TIMEOUT != 0) && (m_frozen == TIMEOUT);
    frz    = acc && !s.rdy && !forced;

    e.chk_regs = !m_first;
    e.err   = m_err;
    e.stall = CNT_W'(m_stall);
    e.flush = CNT_W'(m_flush);
    {e.dmem_req, e.pc_write, e.ifid_write, e.exmem_write} = {acc, 3'b111};
    {e.ifid_flush, e.idex_flush, e.memwb_bubble} = 3'b000;
    if (s.rst) begin
      {e.dmem_req, e.pc_write, e.ifid_write, e.exmem_write} = 4'b0000;
      {e.ifid_flush, e.idex_flush, e.memwb_bubble} = 3'b111;
      m_stall = 0; m_flush = 0; m_err = 0; m_frozen = 0;
    end else begin
      if (frz) begin
        {e.pc_write, e.ifid_write, e.exmem_write, e.memwb_bubble} = 4'b0001;
        m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      end else if (s.br) begin
        {e.ifid_flush, e.idex_flush} = 2'b11;
        m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
      end else if (lu) begin
        {e.pc_write, e.ifid_write, e.idex_flush} = 3'b001;
        m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      end
      if (forced) m_err = 1;
      m_frozen = frz ? m_frozen + 1 : 0;
    end
    m_first = 0;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Monitor: every cycle the DUT presents a decoded response; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("dmem_req",     16'(dmem_req),     16'(e.dmem_req));
        checkOutput("pc_write",     16'(pc_write),     16'(e.pc_write));
        checkOutput("ifid_write",   16'(ifid_write),   16'(e.ifid_write));
        checkOutput("exmem_write",  16'(exmem_write),  16'(e.exmem_write));
        checkOutput("ifid_flush",   16'(ifid_flush),   16'(e.ifid_flush));
        checkOutput("idex_flush",   16'(idex_flush),   16'(e.idex_flush));
        checkOutput("memwb_bubble", 16'(memwb_bubble), 16'(e.memwb_bubble));
        if (e.chk_regs) begin
          checkOutput("err_timeout", 16'(err_timeout), 16'(e.err));
          checkOutput("stall_cnt",   16'(stall_cnt),   16'(e.stall));
          checkOutput("flush_cnt",   16'(flush_cnt),   16'(e.flush));
        end
      end
    end
  end

  initial begin
    stim_t idle;
    int budget;
    idle = mk(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0);
    reset = 1'b1;
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_uses_rs2, ex_MemRead, ex_branch_taken, mem_MemRead, mem_MemWrite, dmem_ready} = '0;

    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    applyStimulus(idle);

    // Load-use on rs1, then the same with ex_rd=0, then branch together with load-use.
    applyStimulus(mk(0, 5'd5, 5'd9, 0, 5'd5, 1, 0, 0, 0, 0));
    applyStimulus(idle);
    applyStimulus(mk(0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0));
    applyStimulus(mk(0, 5'd7, 5'd6, 1, 5'd6, 1, 1, 0, 0, 0));
    applyStimulus(idle);

    // Three-cycle memory wait with a branch pending during the freeze, then ready.
    for (int i = 0; i < 3; i++) applyStimulus(mk(0, 5'd1, 5'd2, 0, 5'd3, 0, 1, 1, 0, 0));
    applyStimulus(mk(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 1));
    applyStimulus(idle);

    // Ready never arrives: forced release, sticky error, then a fresh wait begins.
    for (int i = 0; i < 7; i++) applyStimulus(mk(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 1, 0));
    applyStimulus(idle);
    applyStimulus(idle);

    // Reset in the middle of a wait, then a cycle with no access.
    applyStimulus(mk(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0));
    applyStimulus(mk(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0));
    applyStimulus(mk(0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0));
    applyStimulus(mk(1, 5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0));
    applyStimulus(idle);
    applyStimulus(idle);

    // Twenty load-use stalls (via rs2) drive the stall counter into saturation.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(mk(0, 5'd4, 5'd8, 1, 5'd8, 1, 0, 0, 0, 0));
      applyStimulus(idle);
    end

    // Random traffic with narrow register ranges so hazards collide often.
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s.rst   = ($urandom_range(0, 99) == 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.uses2 = 1'($urandom);
      s.rd    = 5'($urandom_range(0, 3));
      s.ld    = ($urandom_range(0, 2) == 0);
      s.br    = ($urandom_range(0, 5) == 0);
      s.mr    = ($urandom_range(0, 3) == 0);
      s.mw    = ($urandom_range(0, 7) == 0);
      s.rdy   = ($urandom_range(0, 9) < 3);
      applyStimulus(s);
    end

    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d responses left unchecked, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
